// File: rtl/mem_access_unit.sv
// Load/store sequencer that sits in front of the memory controller and keeps one request in flight.
// Define MEM_ACC_RANGE_CHK_EN to reject requests whose address is at or above ADDR_LIMIT.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32'd16
`endif

module mem_access_unit #(
  parameter int unsigned     DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned     RD_LAT     = 32'd1,
  parameter longint unsigned ADDR_LIMIT = 64'h8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            mc_action,
  output logic [DATA_WIDTH-1:0] mc_address,
  output logic [DATA_WIDTH-1:0] mc_data,
  input  logic [DATA_WIDTH-1:0] mc_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] RD_LAT_M1 = 4'(RD_LAT - 32'd1);

  if ((RD_LAT < 32'd1) || (RD_LAT > 32'd15)) begin : g_bad_rd_lat
    $error("mem_access_unit: RD_LAT=%0d is outside 1..15", RD_LAT);
  end
  if (ADDR_LIMIT > (64'd1 << DATA_WIDTH)) begin : g_bad_addr_limit
    $error("mem_access_unit: ADDR_LIMIT does not fit the address width");
  end

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            mc_action_q, mc_action_d;
  logic [DATA_WIDTH-1:0] mc_address_q, mc_address_d;
  logic [DATA_WIDTH-1:0] mc_data_q, mc_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  addr_bad_s;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    mc_action_d  = 2'b00;
    mc_address_d = mc_address_q;
    mc_data_d    = mc_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
`ifdef MEM_ACC_RANGE_CHK_EN
    addr_bad_s   = (64'(req_addr) >= ADDR_LIMIT);
`else
    addr_bad_s   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
          if (addr_bad_s) begin
            // Rejected requests never reach the controller; answer on the next cycle.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d      = ISSUE;
            mc_action_d  = req_we ? 2'b10 : 2'b01;
            mc_address_d = req_addr;
            mc_data_d    = req_wdata;
            rsp_err_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          state_d = WAIT;
          cnt_d   = RD_LAT_M1;
        end
      end
      WAIT: begin
        // Counter reaching zero marks the cycle in which mc_rdata is valid.
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mc_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      mc_action_q  <= 2'b00;
      mc_address_q <= {DATA_WIDTH{1'b0}};
      mc_data_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= {DATA_WIDTH{1'b0}};
      rsp_err_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      mc_action_q  <= mc_action_d;
      mc_address_q <= mc_address_d;
      mc_data_q    <= mc_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mc_action  = mc_action_q;
  assign mc_address = mc_address_q;
  assign mc_data    = mc_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a latency-accurate controller model and a response scoreboard.
`timescale 1ns/1ps

module tb_mem_access_unit;

  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [1:0]  mc_action;
  logic [15:0] mc_address, mc_data, mc_rdata;
  logic        busy;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   rd_due = -1;
  logic [15:0] rd_val;
  exp_t sb[$];

  mem_access_unit #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mc_action(mc_action), .mc_address(mc_address), .mc_data(mc_data), .mc_rdata(mc_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return a + 16'h1234;
  endfunction

  // Controller model: read data is valid only in the cycle RD_LAT after the issue cycle.
  always @(negedge clk) begin
    if (mc_action == 2'b01) begin
      rd_due <= cyc + RD_LAT;
      rd_val <= mem_model(mc_address);
    end
    mc_rdata <= (cyc == rd_due) ? rd_val : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int hold, input logic exp_issue, input int exp_lat);
    int   n;
    exp_t e;
    exp_t got;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
    check("accept_ready", 32'(req_ready), 32'd1);
    e.rdata = (we || !exp_issue) ? 16'h0000 : mem_model(addr);
    e.err   = !exp_issue;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    check("issue_action", 32'(mc_action), exp_issue ? (we ? 32'd2 : 32'd1) : 32'd0);
    if (exp_issue) begin
      check("issue_addr", 32'(mc_address), 32'(addr));
      check("issue_data", 32'(mc_data), 32'(wdata));
    end
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin
      check("busy_no_ready", 32'(req_ready), 32'd0);
      step(); n++;
      check("action_quiet", 32'(mc_action), 32'd0);
    end
    check("rsp_latency", n, exp_lat);
    for (int i = 0; i < hold; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", 32'(rsp_rdata), 32'(e.rdata));
      check("stall_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    got = sb.pop_front();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
    check("rsp_err", 32'(rsp_err), 32'(got.err));
    step();
    rsp_ready = 1'b0;
    check("rsp_cleared", 32'(rsp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t       e;
    logic [1:0] exp_act;
    int         last_acc, acc;
    logic       last_we, hs_prev;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000; rsp_ready = 1'b0;
    repeat (3) step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_action", 32'(mc_action), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_address", 32'(mc_address), 32'd0);
    rst = 1'b0;
    step(); step();
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    do_req(1'b1, 16'h0010, 16'hBEEF, 0, 1'b1, 2);
    do_req(1'b0, 16'h0000, 16'h0000, 3, 1'b1, 2 + RD_LAT);
    do_req(1'b1, 16'h7FFF, 16'h0001, 1, 1'b1, 2);
`ifdef MEM_ACC_RANGE_CHK_EN
    do_req(1'b0, 16'h9000, 16'h0000, 0, 1'b0, 1);
    do_req(1'b0, 16'h7FFF, 16'h0000, 0, 1'b1, 2 + RD_LAT);
    do_req(1'b1, 16'h8000, 16'h5555, 1, 1'b0, 1);
    check("reject_keeps_addr", 32'(mc_address), 32'h7FFF);
`else
    do_req(1'b0, 16'h9000, 16'h0000, 0, 1'b1, 2 + RD_LAT);
`endif

    // Back-to-back traffic with request held valid and response always accepted.
    req_valid = 1'b1; rsp_ready = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 16'hA5A0;
    exp_act = 2'b00; last_acc = -1; last_we = 1'b0; acc = 0; hs_prev = 1'b0;
    for (int c = 0; c < 200 && (acc < 8 || sb.size() != 0); c++) begin
      check("b2b_action", 32'(mc_action), 32'(exp_act));
      if (hs_prev) check("b2b_accept_after_rsp", 32'(req_ready), 32'd1);
      hs_prev = rsp_valid;
      exp_act = 2'b00;
      if (rsp_valid) begin
        check("b2b_rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("b2b_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("b2b_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (req_valid && req_ready) begin
        if (last_acc >= 0) check("b2b_gap", cyc - last_acc, last_we ? 3 : 3 + RD_LAT);
        last_acc = cyc; last_we = req_we;
        e.rdata = req_we ? 16'h0000 : mem_model(req_addr);
        e.err   = 1'b0;
        sb.push_back(e);
        exp_act = req_we ? 2'b10 : 2'b01;
        acc++;
        step();
        req_we = ~req_we; req_addr = req_addr + 16'h0011; req_wdata = req_wdata ^ 16'h0F0F;
        if (acc >= 8) req_valid = 1'b0;
      end else begin
        step();
      end
    end
    check("b2b_accepts", acc, 8);
    check("b2b_drained", sb.size(), 0);
    rsp_ready = 1'b0;

    // Reset while the read is in ISSUE: action must drop without waiting for a clock.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
    check("abort1_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("abort1_issue", 32'(mc_action), 32'd1);
    rst = 1'b1;
    #1;
    check("abort1_action", 32'(mc_action), 32'd0);
    check("abort1_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("abort1_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    check("abort1_ready_after", 32'(req_ready), 32'd1);

    // Reset while the read is waiting for data.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
    step();
    req_valid = 1'b0;
    step();
    check("abort2_in_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort2_action", 32'(mc_action), 32'd0);
    check("abort2_req_ready", 32'(req_ready), 32'd0);
    check("abort2_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort2_rdata", 32'(rsp_rdata), 32'd0);
    check("abort2_data", 32'(mc_data), 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("abort2_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    check("abort2_ready_after", 32'(req_ready), 32'd1);
    check("abort2_busy_after", 32'(busy), 32'd0);

    do_req(1'b0, 16'h0abc, 16'h0000, 0, 1'b1, 2 + RD_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
